// File: rtl/mem_loader.sv
// mem_loader: streams a host word block into memory over the debug port, then re-reads it and compares against a second pass of the same stream.
module mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              setup_mem,
    output logic              verify_mem,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, DONE} state_t;
    localparam int DW = $clog2(RD_LAT + 2);
    localparam logic [ADDR_W:0] ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, first_q, first_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, iss_q, iss_d, errc_q, errc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              setup_q, setup_d, verify_q, verify_d, error_q, error_d, done_q, done_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [DATA_W-1:0] exp_q [0:RD_LAT];
    logic [ADDR_W-1:0] eaddr_q [0:RD_LAT];
    logic [RD_LAT:0]   vld_q;
    logic              xfer, last, kill, mismatch;

    assign in_ready       = state_q == LOAD || (state_q == VERIFY && iss_q < cnt_q);
    assign xfer           = in_valid && in_ready;
    assign last           = iss_q + ONE == cnt_q;
    assign kill           = abort && state_q != IDLE;
    assign mismatch       = vld_q[RD_LAT] && mem_rdata != exp_q[RD_LAT] && !kill;
    assign setup_mem      = setup_q;
    assign verify_mem     = verify_q;
    assign mem_addr_out   = addr_q;
    assign mem_wdata      = wdata_q;
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign error          = error_q;
    assign err_count      = errc_q;
    assign first_err_addr = first_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        iss_d    = iss_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        drain_d  = drain_q;
        setup_d  = 1'b0;
        verify_d = 1'b0;
        done_d   = 1'b0;
        error_d  = error_q || mismatch;
        errc_d   = mismatch ? errc_q + ONE : errc_q;
        first_d  = mismatch && errc_q == '0 ? eaddr_q[RD_LAT] : first_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                base_d  = base_addr;
                cnt_d   = word_count;
                iss_d   = '0;
                error_d = 1'b0;
                errc_d  = '0;
                first_d = '0;
                state_d = word_count == '0 ? DONE : LOAD;
            end
            LOAD: if (xfer) begin
                setup_d = 1'b1;
                addr_d  = base_q + iss_q[ADDR_W-1:0];
                wdata_d = in_data;
                iss_d   = last ? '0 : iss_q + ONE;
                state_d = last ? VERIFY : LOAD;
            end
            VERIFY: if (xfer) begin
                verify_d = 1'b1;
                addr_d   = base_q + iss_q[ADDR_W-1:0];
                iss_d    = iss_q + ONE;
                drain_d  = '0;
                state_d  = last ? DRAIN : VERIFY;
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                state_d = drain_q == DW'(RD_LAT) ? DONE : DRAIN;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d  = IDLE;
            setup_d  = 1'b0;
            verify_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            iss_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            drain_q  <= '0;
            setup_q  <= 1'b0;
            verify_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            errc_q   <= '0;
            first_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                exp_q[i]   <= '0;
                eaddr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            iss_q    <= iss_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            drain_q  <= drain_d;
            setup_q  <= setup_d;
            verify_q <= verify_d;
            done_q   <= done_d;
            error_q  <= error_d;
            errc_q   <= errc_d;
            first_q  <= first_d;
            // stage 0 lines up with the verify strobe; stage RD_LAT with mem_rdata
            vld_q      <= kill ? '0 : {vld_q[RD_LAT-1:0], verify_d};
            exp_q[0]   <= in_data;
            eaddr_q[0] <= addr_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                exp_q[i]   <= exp_q[i-1];
                eaddr_q[i] <= eaddr_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed scenarios for mem_loader against a one-cycle-latency memory model.
module tb_mem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic [63:0] in_data = '0, mem_rdata = '0;
    logic        in_ready, setup_mem, verify_mem, busy, done, error;
    logic [9:0]  mem_addr_out, first_err_addr;
    logic [63:0] mem_wdata;
    logic [10:0] err_count;

    int n_checks = 0, n_fail = 0;
    logic [63:0] mem [0:1023];
    logic        corrupt_en = 1'b0;
    logic [9:0]  corrupt_addr = '0;
    logic [9:0]  wr_a [$];
    logic [63:0] wr_d [$];
    int rd_n = 0, both_n = 0, done_n = 0, rdy_n = 0;

    mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .setup_mem(setup_mem), .verify_mem(verify_mem),
        .mem_addr_out(mem_addr_out), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .error(error),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (setup_mem) mem[mem_addr_out] <= mem_wdata;
        if (verify_mem) mem_rdata <= mem[mem_addr_out] ^ ((corrupt_en && mem_addr_out == corrupt_addr) ? 64'h1 : 64'h0);
    end

    always @(negedge clk) begin
        if (setup_mem) begin
            wr_a.push_back(mem_addr_out);
            wr_d.push_back(mem_wdata);
        end
        if (verify_mem) rd_n++;
        if (setup_mem && verify_mem) both_n++;
        if (done) done_n++;
        if (in_ready) rdy_n++;
    end

    task automatic clr();
        @(posedge clk); #1;
        wr_a.delete(); wr_d.delete();
        rd_n = 0; both_n = 0; done_n = 0; rdy_n = 0;
    endtask

    task automatic run_job(input logic [9:0] base, input logic [10:0] cnt, input logic [63:0] pat,
                           input bit gap, input bit spam, input int xfers);
        int k = 0, cyc = 0;
        clr();
        @(negedge clk);
        start = 1'b1; base_addr = base; word_count = cnt;
        while (k < xfers && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            start     = spam && (cyc % 300 == 7);
            base_addr = spam ? 10'h155 : base;
            in_valid  = !(gap && cyc % 2 == 0);
            in_data   = pat + 64'(k % int'(cnt));
            if (in_valid && in_ready) k++;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        n_checks++;
        if (k !== xfers) begin n_fail++; $display("FAIL stream_timeout: transferred %0d, required %0d", k, xfers); end
        if (xfers == 2 * int'(cnt)) begin
            for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
            n_checks++;
            if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b, required 1", done); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, setup_mem, verify_mem, busy, done, error, err_count, first_err_addr, mem_addr_out, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: rdy=%b set=%b ver=%b busy=%b done=%b err=%b cnt=%h first=%h addr=%h wd=%h, required all 0",
                               in_ready, setup_mem, verify_mem, busy, done, error, err_count, first_err_addr, mem_addr_out, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_happy();
        run_job(10'h010, 11'd4, 64'hAAAA_0000_0000_00A0, 1'b0, 1'b0, 8);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL happy_error: got %b, required 0", error); end
        n_checks++; if (err_count !== 11'd0) begin n_fail++; $display("FAIL happy_err_count: got %0d, required 0", err_count); end
        repeat (3) @(negedge clk);
        clr_free_check_happy: begin
            n_checks++; if (wr_a.size() !== 4) begin n_fail++; $display("FAIL happy_writes: got %0d, required 4", wr_a.size()); end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_a[i] !== 10'h010 + 10'(i) || wr_d[i] !== 64'hAAAA_0000_0000_00A0 + 64'(i)) begin
                    n_fail++; $display("FAIL happy_write%0d: got %h/%h, required %h/%h", i, wr_a[i], wr_d[i], 10'h010 + 10'(i), 64'hAAAA_0000_0000_00A0 + 64'(i));
                end
            end
            n_checks++; if (rd_n !== 4) begin n_fail++; $display("FAIL happy_reads: got %0d, required 4", rd_n); end
            n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL happy_done_pulses: got %0d, required 1", done_n); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL happy_busy: got %b, required 0", busy); end
        end
    endtask

    task automatic test_mismatch();
        corrupt_en = 1'b1; corrupt_addr = 10'h012;
        run_job(10'h010, 11'd4, 64'h5555_1234_0000_00B0, 1'b0, 1'b0, 8);
        corrupt_en = 1'b0;
        n_checks++;
        if ({error, err_count, first_err_addr} !== {1'b1, 11'd1, 10'h012}) begin
            n_fail++; $display("FAIL mismatch_result: error=%b cnt=%0d first=%h, required 1/1/012", error, err_count, first_err_addr);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if ({error, err_count, first_err_addr} !== {1'b1, 11'd1, 10'h012}) begin
            n_fail++; $display("FAIL mismatch_hold: error=%b cnt=%0d first=%h, required 1/1/012", error, err_count, first_err_addr);
        end
    endtask

    task automatic test_wrap_backpressure();
        run_job(10'h3FE, 11'd4, 64'h0F0F_0000_0000_00C0, 1'b1, 1'b0, 8);
        n_checks++;
        if ({error, err_count} !== 12'd0) begin n_fail++; $display("FAIL wrap_error: error=%b cnt=%0d, required 0/0", error, err_count); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_a.size() !== 4 || wr_a[0] !== 10'h3FE || wr_a[1] !== 10'h3FF || wr_a[2] !== 10'h000 || wr_a[3] !== 10'h001) begin
            n_fail++; $display("FAIL wrap_addrs: n=%0d %h %h %h %h, required 3fe 3ff 000 001", wr_a.size(), wr_a[0], wr_a[1], wr_a[2], wr_a[3]);
        end
        n_checks++; if (rd_n !== 4 || done_n !== 1) begin n_fail++; $display("FAIL wrap_reads_done: reads=%0d done=%0d, required 4/1", rd_n, done_n); end
    endtask

    task automatic test_zero_count();
        clr();
        @(negedge clk);
        start = 1'b1; base_addr = 10'h005; word_count = 11'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL zero_t1: busy=%b done=%b, required 1/0", busy, done); end
        @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL zero_t2: busy=%b done=%b, required 0/1", busy, done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_t3: done=%b, required 0", done); end
        @(posedge clk); #1;
        n_checks++;
        if (wr_a.size() !== 0 || rd_n !== 0 || rdy_n !== 0) begin
            n_fail++; $display("FAIL zero_no_access: writes=%0d reads=%0d ready=%0d, required 0/0/0", wr_a.size(), rd_n, rdy_n);
        end
        n_checks++;
        if ({error, err_count, first_err_addr} !== '0) begin
            n_fail++; $display("FAIL zero_cleared: error=%b cnt=%0d first=%h, required 0", error, err_count, first_err_addr);
        end
    endtask

    task automatic test_abort();
        run_job(10'h020, 11'd4, 64'h1111_0000_0000_00D0, 1'b0, 1'b0, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, in_ready, setup_mem, verify_mem} !== 4'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b rdy=%b set=%b ver=%b, required 0", busy, in_ready, setup_mem, verify_mem);
        end
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        n_checks++; if (done_n !== 0 || rd_n !== 2) begin n_fail++; $display("FAIL abort_done: done=%0d reads=%0d, required 0/2", done_n, rd_n); end
    endtask

    task automatic test_reset_mid_load();
        run_job(10'h040, 11'd8, 64'h2222_0000_0000_00E0, 1'b0, 1'b0, 3);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, setup_mem, verify_mem, busy, done, error, err_count, first_err_addr, mem_addr_out, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL midload_reset: rdy=%b set=%b busy=%b addr=%h wd=%h, required all 0", in_ready, setup_mem, busy, mem_addr_out, mem_wdata);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        n_checks++; if (done_n !== 0) begin n_fail++; $display("FAIL midload_done: got %0d, required 0", done_n); end
        run_job(10'h010, 11'd4, 64'hAAAA_0000_0000_00A0, 1'b0, 1'b0, 8);
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_a.size() !== 4 || wr_a[0] !== 10'h010 || rd_n !== 4 || done_n !== 1 || {error, err_count} !== 12'd0) begin
            n_fail++; $display("FAIL midload_rerun: writes=%0d a0=%h reads=%0d done=%0d err=%b cnt=%0d, required 4/010/4/1/0/0",
                               wr_a.size(), wr_a[0], rd_n, done_n, error, err_count);
        end
    endtask

    task automatic test_full_depth();
        run_job(10'h000, 11'd1024, 64'hFACE_0000_0000_0000, 1'b0, 1'b1, 2048);
        n_checks++; if ({error, err_count} !== 12'd0) begin n_fail++; $display("FAIL full_error: error=%b cnt=%0d, required 0/0", error, err_count); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_a.size() !== 1024 || rd_n !== 1024 || both_n !== 0 || done_n !== 1) begin
            n_fail++; $display("FAIL full_counts: writes=%0d reads=%0d both=%0d done=%0d, required 1024/1024/0/1", wr_a.size(), rd_n, both_n, done_n);
        end
        n_checks++;
        if (wr_a[0] !== 10'h000 || wr_a[1023] !== 10'h3FF || wr_d[1023] !== 64'hFACE_0000_0000_03FF) begin
            n_fail++; $display("FAIL full_ends: a0=%h a1023=%h d1023=%h, required 000/3ff/face0000000003ff", wr_a[0], wr_a[1023], wr_d[1023]);
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_mismatch();
        test_wrap_backpressure();
        test_zero_count();
        test_abort();
        test_reset_mid_load();
        test_full_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, memory debug-port address width; 1024-word space.
REQ-002 Parameter DATA_W, default 64, memory word width.
REQ-003 Parameter RD_LAT, default 1, cycles from verify_mem/address valid to mem_rdata valid.
REQ-004 Ports:
- clk  input  1  sole clock; all logic rising-edge.
- reset  input  1  synchronous, active-high.
- start  input  1  single-cycle pulse; begins a load+verify job; ignored while busy=1.
- abort  input  1  single-cycle pulse; terminates the job.
- base_addr  input  ADDR_W  first memory address; sampled on accepted start.
- word_count  input  ADDR_W+1  number of words, 0..1024; sampled on accepted start.
- in_data  input  DATA_W  host word stream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- setup_mem  output  1  memory write strobe to processor debug port.
- verify_mem  output  1  memory read strobe to processor debug port.
- mem_addr_out  output  ADDR_W  debug-port address.
- mem_wdata  output  DATA_W  debug-port write data.
- mem_rdata  input  DATA_W  debug-port read data.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at job completion.
- error  output  1  sticky: at least one verify mismatch in the current or last job.
- err_count  output  ADDR_W+1  mismatch count for the current or last job.
- first_err_addr  output  ADDR_W  address of the first mismatch.

Function
REQ-005 FSM states: IDLE, LOAD, VERIFY, DRAIN, DONE.
REQ-006 IDLE: start=1 latches base_addr and word_count, clears error, err_count, and first_err_addr, and sets busy=1 the next cycle. The next state is LOAD, or DONE if word_count=0, in which case no memory access occurs.
REQ-007 Handshake: a word transfers on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in LOAD, and in VERIFY while issued<word_count; in_ready=0 in all other states.
REQ-008 LOAD: the k-th transfer (k=0..N-1) drives setup_mem=1, mem_addr_out=(base_addr+k) mod 2^ADDR_W, and mem_wdata=in_data in the following cycle; all three are registered.
REQ-009 The N-th LOAD transfer moves the FSM to VERIFY; the host re-streams the same N words in the same order.
REQ-010 VERIFY: the k-th transfer drives verify_mem=1 and mem_addr_out=(base_addr+k) mod 2^ADDR_W in the following cycle. The expected word and address are delayed through a pipeline so that they align with mem_rdata RD_LAT cycles after the strobe.
REQ-011 setup_mem and verify_mem are never both 1 in the same cycle; both are 0 when no access is issued, and the previous address and data are held.
REQ-012 Compare: when mem_rdata != expected word, err_count increments, error is set, and first_err_addr captures that address only on the first mismatch of the job.
REQ-013 After the N-th VERIFY transfer the FSM enters DRAIN and remains there until the last compare completes, which takes RD_LAT+1 cycles.
REQ-014 DONE: done=1 for exactly one cycle; the FSM then returns to IDLE and busy=0 in that same IDLE cycle.
REQ-015 error, err_count, and first_err_addr hold after the job completes until the next accepted start or reset.
REQ-016 abort in any non-IDLE state forces IDLE the next cycle.
- busy=0, in_ready=0, setup_mem=0, verify_mem=0 at that point; done is not pulsed.
- In-flight compares are discarded; error, err_count, and first_err_addr keep their values.
REQ-017 If abort and start are asserted together in IDLE, abort wins and start is ignored.
REQ-018 Address wrap: (base_addr+k) wraps 1023 to 0 with no error indication.
REQ-019 Backpressure is host-side only: gaps in in_valid stall progress without affecting results.

Reset
REQ-020 reset=1 forces IDLE on the next edge and overrides start and abort.
REQ-021 After reset, every output is 0: in_ready, setup_mem, verify_mem, busy, done, error, err_count, first_err_addr, mem_addr_out, mem_wdata.
REQ-022 Reset mid-job discards all progress; no done pulse is produced.

Verification
REQ-023 Happy path: base=0x010, count=4, words A0..A3 streamed twice, memory model correct -> four writes to 0x010..0x013, four reads, done pulses once, error=0, err_count=0.
REQ-024 Mismatch: memory model corrupts address 0x012 -> error=1, err_count=1, first_err_addr=0x012.
REQ-025 Wrap and backpressure: base=0x3FE, count=4, in_valid toggling 1/0 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001; results match the no-gap run.
REQ-026 Zero count: start with word_count=0 -> no setup_mem or verify_mem strobes, in_ready stays 0, done pulses 2 cycles after start.
REQ-027 Abort and reset: abort during VERIFY after two reads -> next cycle busy=0 and no done pulse. Reset mid-LOAD -> all outputs 0 and the next start behaves as from power-up.
REQ-028 Full depth: count=1024, base=0 -> 1024 writes and 1024 reads with no simultaneous setup_mem/verify_mem; start pulses during the job are ignored.
